// File: rtl/ifetch_q.sv
// ==== ifetch_q : fetch, predecode (JAL/branch/JALR) and instruction queue -- rev 1.0 ====
`default_nettype none

module ifetch_q #(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BP_MODE  = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    output logic                          icache_req,
    output logic [31:0]                   icache_pc,
    input  logic                          icache_valid,
    input  logic [31:0]                   icache_inst,
    output logic [31:0]                   pred_pc,
    input  logic                          pred_taken,
    output logic                          upd_valid,
    output logic [31:0]                   upd_pc,
    output logic                          upd_taken,
    output logic                          dec_valid,
    output logic [31:0]                   dec_inst,
    output logic [31:0]                   dec_pc,
    output logic                          dec_pred_taken,
    input  logic                          dec_ready,
    input  logic                          jalr_finish,
    input  logic [31:0]                   jalr_target,
    input  logic                          br_finish,
    input  logic [31:0]                   br_pc,
    input  logic                          br_pred,
    input  logic                          br_taken,
    input  logic [31:0]                   br_redirect_pc,
    output logic [$clog2(IQ_DEPTH):0]     iq_count
);

    localparam int AW = $clog2(IQ_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_IC    = 2'd1,
        S_STALL_JALR = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   head_q, tail_q;
    logic            req_q;
    logic [31:0]     icache_pc_q;
    logic            upd_valid_q;
    logic [31:0]     upd_pc_q;
    logic            upd_taken_q;

    logic [31:0]     inst_mem_q [IQ_DEPTH];
    logic [31:0]     pc_mem_q   [IQ_DEPTH];
    logic            pred_mem_q [IQ_DEPTH];

    logic            flush_w;
    logic            push_w;
    logic            push_pred_w;
    logic            pop_w;
    logic            issue_w;
    logic            bp_taken_w;
    logic [31:0]     jimm_w;
    logic [31:0]     bimm_w;

    assign flush_w = br_finish && (br_pred != br_taken);

    assign jimm_w = {{11{icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                     icache_inst[20], icache_inst[30:21], 1'b0};
    assign bimm_w = {{19{icache_inst[31]}}, icache_inst[31], icache_inst[7],
                     icache_inst[30:25], icache_inst[11:8], 1'b0};

    // Mode 2 predicts taken exactly when the offset is negative (backward branch).
    assign bp_taken_w = (BP_MODE == 1) ? pred_taken :
                        (BP_MODE == 2) ? icache_inst[31] : 1'b0;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        push_w      = 1'b0;
        push_pred_w = 1'b0;
        if (drop_q && icache_valid) begin
            drop_d = 1'b0;
        end
        if (flush_w) begin
            pc_d    = br_redirect_pc;
            state_d = S_IDLE;
            if (state_q == S_WAIT_IC && !icache_valid) begin
                drop_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_WAIT_IC: begin
                    if (icache_valid) begin
                        push_w  = 1'b1;
                        state_d = S_IDLE;
                        case (icache_inst[6:0])
                            OP_JAL:    pc_d = pc_q + jimm_w;
                            OP_BRANCH: begin
                                push_pred_w = bp_taken_w;
                                pc_d        = bp_taken_w ? (pc_q + bimm_w) : (pc_q + 32'd4);
                            end
                            OP_JALR:   state_d = S_STALL_JALR;
                            default:   pc_d = pc_q + 32'd4;
                        endcase
                    end
                end
                S_STALL_JALR: begin
                    if (jalr_finish) begin
                        pc_d    = jalr_target;
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
        pop_w   = (count_q != '0) && dec_ready && !flush_w;
        count_d = flush_w ? '0 : (count_q + CW'(push_w) - CW'(pop_w));
        // Issue in the same edge that returns to IDLE so a redirect fetches one cycle later.
        issue_w = (state_d == S_IDLE) && !drop_d && (count_d < CW'(IQ_DEPTH));
        if (issue_w) begin
            state_d = S_WAIT_IC;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            req_q       <= 1'b0;
            icache_pc_q <= 32'h0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= 32'h0;
            upd_taken_q <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            req_q       <= issue_w;
            if (issue_w) begin
                icache_pc_q <= pc_d;
            end
            if (flush_w) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push_w) tail_q <= tail_q + AW'(1);
                if (pop_w)  head_q <= head_q + AW'(1);
            end
            upd_valid_q <= br_finish;
            if (br_finish) begin
                upd_pc_q    <= br_pc;
                upd_taken_q <= br_taken;
            end
        end else begin
            req_q       <= 1'b0;
            upd_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && push_w) begin
            inst_mem_q[tail_q] <= icache_inst;
            pc_mem_q[tail_q]   <= pc_q;
            pred_mem_q[tail_q] <= push_pred_w;
        end
    end

    assign icache_req     = req_q;
    assign icache_pc      = icache_pc_q;
    assign pred_pc        = pc_q;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign dec_valid      = (count_q != '0);
    assign dec_inst       = inst_mem_q[head_q];
    assign dec_pc         = pc_mem_q[head_q];
    assign dec_pred_taken = pred_mem_q[head_q];
    assign iq_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_q.sv
// ==== tb_ifetch_q : directed self-checking bench for ifetch_q -- rev 1.0 ====
`default_nettype none

module tb_ifetch_q;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] JAL20   = 32'h0200006F;
    localparam logic [31:0] BR_BACK = 32'hFE000CE3;
    localparam logic [31:0] BR_FWD  = 32'h00000463;
    localparam logic [31:0] JALR    = 32'h00008067;

    logic        clk_in, rst_in, rdy_in;
    logic        icache_valid, pred_taken, dec_ready, jalr_finish;
    logic [31:0] icache_inst, jalr_target;
    logic        br_finish, br_pred, br_taken;
    logic [31:0] br_pc, br_redirect_pc;

    logic        icache_req, upd_valid, upd_taken, dec_valid, dec_pred_taken;
    logic [31:0] icache_pc, pred_pc, upd_pc, dec_inst, dec_pc;
    logic [2:0]  iq_count;

    logic        b_icache_req, b_upd_valid, b_upd_taken, b_dec_valid, b_dec_pred_taken;
    logic [31:0] b_icache_pc, b_pred_pc, b_upd_pc, b_dec_inst, b_dec_pc;
    logic [2:0]  b_iq_count;

    int checks   = 0;
    int failures = 0;

    ifetch_q #(.IQ_DEPTH(4), .RESET_PC(32'h0), .BP_MODE(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req(icache_req), .icache_pc(icache_pc),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_pred_taken(dec_pred_taken), .dec_ready(dec_ready),
        .jalr_finish(jalr_finish), .jalr_target(jalr_target),
        .br_finish(br_finish), .br_pc(br_pc), .br_pred(br_pred), .br_taken(br_taken),
        .br_redirect_pc(br_redirect_pc), .iq_count(iq_count)
    );

    ifetch_q #(.IQ_DEPTH(4), .RESET_PC(32'h0), .BP_MODE(0)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req(b_icache_req), .icache_pc(b_icache_pc),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .pred_pc(b_pred_pc), .pred_taken(pred_taken),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
        .dec_valid(b_dec_valid), .dec_inst(b_dec_inst), .dec_pc(b_dec_pc),
        .dec_pred_taken(b_dec_pred_taken), .dec_ready(dec_ready),
        .jalr_finish(jalr_finish), .jalr_target(jalr_target),
        .br_finish(br_finish), .br_pc(br_pc), .br_pred(br_pred), .br_taken(br_taken),
        .br_redirect_pc(br_redirect_pc), .iq_count(b_iq_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle icache latency: the response follows the request by one cycle.
    task automatic respond(input logic [31:0] inst);
        step();
        icache_valid = 1'b1;
        icache_inst  = inst;
        step();
        icache_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; icache_valid = 1'b0; icache_inst = 32'h0;
        pred_taken = 1'b0; dec_ready = 1'b1; jalr_finish = 1'b0; jalr_target = 32'h0;
        br_finish = 1'b0; br_pc = 32'h0; br_pred = 1'b0; br_taken = 1'b0; br_redirect_pc = 32'h0;
        step(); step();
        checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", icache_req); end
        checks++; if (icache_pc !== 32'h0) begin failures++; $display("FAIL reset_icache_pc got=%h exp=0", icache_pc); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
        checks++; if (iq_count !== 3'd0) begin failures++; $display("FAIL reset_iq_count got=%0d exp=0", iq_count); end
        checks++; if (upd_valid !== 1'b0 || upd_pc !== 32'h0 || upd_taken !== 1'b0) begin
            failures++; $display("FAIL reset_upd got=%b/%h/%b exp=0/0/0", upd_valid, upd_pc, upd_taken); end
        rst_in = 1'b1;
        step();
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h0) begin
            failures++; $display("FAIL first_fetch got=%b/%h exp=1/00000000", icache_req, icache_pc); end
    endtask

    task automatic test_straight();
        for (int i = 0; i < 4; i++) begin
            checks++; if (icache_req !== 1'b1 || icache_pc !== 32'(i * 4)) begin
                failures++; $display("FAIL straight_req[%0d] got=%b/%h exp=1/%h", i, icache_req, icache_pc, 32'(i * 4)); end
            respond(NOP);
            checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(i * 4) || dec_inst !== NOP || dec_pred_taken !== 1'b0) begin
                failures++; $display("FAIL straight_dec[%0d] got=%b/%h/%h/%b exp=1/%h/%h/0",
                                     i, dec_valid, dec_pc, dec_inst, dec_pred_taken, 32'(i * 4), NOP); end
        end
    endtask

    task automatic test_jal();
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h10) begin
            failures++; $display("FAIL jal_fetch got=%b/%h exp=1/00000010", icache_req, icache_pc); end
        respond(JAL20);
        checks++; if (dec_pc !== 32'h10 || dec_inst !== JAL20) begin
            failures++; $display("FAIL jal_dec got=%h/%h exp=00000010/%h", dec_pc, dec_inst, JAL20); end
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h30) begin
            failures++; $display("FAIL jal_target got=%b/%h exp=1/00000030", icache_req, icache_pc); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) respond(NOP);
        checks++; if (icache_pc !== 32'h40 || b_icache_pc !== 32'h40) begin
            failures++; $display("FAIL br_fetch got=%h/%h exp=00000040/00000040", icache_pc, b_icache_pc); end
        respond(BR_BACK);
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h38) begin
            failures++; $display("FAIL btfn_back_target got=%b/%h exp=1/00000038", icache_req, icache_pc); end
        checks++; if (dec_pc !== 32'h40 || dec_pred_taken !== 1'b1) begin
            failures++; $display("FAIL btfn_back_pred got=%h/%b exp=00000040/1", dec_pc, dec_pred_taken); end
        checks++; if (b_icache_req !== 1'b1 || b_icache_pc !== 32'h44 || b_dec_pred_taken !== 1'b0) begin
            failures++; $display("FAIL static_nt got=%b/%h/%b exp=1/00000044/0", b_icache_req, b_icache_pc, b_dec_pred_taken); end
        respond(BR_FWD);
        checks++; if (icache_pc !== 32'h3C || dec_pc !== 32'h38 || dec_pred_taken !== 1'b0) begin
            failures++; $display("FAIL btfn_fwd got=%h/%h/%b exp=0000003c/00000038/0", icache_pc, dec_pc, dec_pred_taken); end
    endtask

    task automatic test_full();
        step();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) respond(NOP);
        checks++; if (iq_count !== 3'd4 || icache_req !== 1'b0 || dec_pc !== 32'h3C) begin
            failures++; $display("FAIL full_state got=%0d/%b/%h exp=4/0/0000003c", iq_count, icache_req, dec_pc); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL full_hold[%0d] got=%b exp=0", i, icache_req); end
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (iq_count !== 3'd3 || icache_req !== 1'b1 || icache_pc !== 32'h4C || dec_pc !== 32'h40) begin
            failures++; $display("FAIL full_pop got=%0d/%b/%h/%h exp=3/1/0000004c/00000040", iq_count, icache_req, icache_pc, dec_pc); end
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b1;
        respond(NOP);
        checks++; if (iq_count !== 3'd2 || dec_pc !== 32'h48 || icache_req !== 1'b1 || icache_pc !== 32'h50) begin
            failures++; $display("FAIL push_pop got=%0d/%h/%b/%h exp=2/00000048/1/00000050", iq_count, dec_pc, icache_req, icache_pc); end
    endtask

    task automatic test_flush();
        br_finish = 1'b1; br_pred = 1'b1; br_taken = 1'b0; br_pc = 32'h40; br_redirect_pc = 32'h80;
        step();
        br_finish = 1'b0;
        checks++; if (dec_valid !== 1'b0 || iq_count !== 3'd0 || icache_req !== 1'b0) begin
            failures++; $display("FAIL flush_clear got=%b/%0d/%b exp=0/0/0", dec_valid, iq_count, icache_req); end
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h40 || upd_taken !== 1'b0) begin
            failures++; $display("FAIL flush_upd got=%b/%h/%b exp=1/00000040/0", upd_valid, upd_pc, upd_taken); end
        step();
        checks++; if (icache_req !== 1'b0 || upd_valid !== 1'b0) begin
            failures++; $display("FAIL flush_wait got=%b/%b exp=0/0", icache_req, upd_valid); end
        icache_valid = 1'b1; icache_inst = JAL20;
        step();
        icache_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0 || icache_req !== 1'b1 || icache_pc !== 32'h80) begin
            failures++; $display("FAIL flush_drop got=%b/%b/%h exp=0/1/00000080", dec_valid, icache_req, icache_pc); end
        respond(JALR);
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h80 || icache_req !== 1'b0) begin
            failures++; $display("FAIL jalr_enq got=%b/%h/%b exp=1/00000080/0", dec_valid, dec_pc, icache_req); end
        br_finish = 1'b1; br_pred = 1'b0; br_taken = 1'b1; br_pc = 32'h44; br_redirect_pc = 32'h20;
        step();
        br_finish = 1'b0;
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h20 || dec_valid !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%b/%h/%b exp=1/00000020/0", icache_req, icache_pc, dec_valid); end
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h44 || upd_taken !== 1'b1) begin
            failures++; $display("FAIL flush_stall_upd got=%b/%h/%b exp=1/00000044/1", upd_valid, upd_pc, upd_taken); end
    endtask

    task automatic test_jalr();
        respond(JALR);
        checks++; if (dec_pc !== 32'h20 || icache_req !== 1'b0) begin
            failures++; $display("FAIL jalr_dec got=%h/%b exp=00000020/0", dec_pc, icache_req); end
        step();
        checks++; if (icache_req !== 1'b0) begin failures++; $display("FAIL jalr_stall got=%b exp=0", icache_req); end
        br_finish = 1'b1; br_pred = 1'b1; br_taken = 1'b1; br_pc = 32'h60; br_redirect_pc = 32'h200;
        step();
        br_finish = 1'b0;
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h60 || upd_taken !== 1'b1 || icache_req !== 1'b0) begin
            failures++; $display("FAIL correct_pred got=%b/%h/%b/%b exp=1/00000060/1/0", upd_valid, upd_pc, upd_taken, icache_req); end
        jalr_finish = 1'b1; jalr_target = 32'h100; rdy_in = 1'b0;
        step();
        checks++; if (icache_req !== 1'b0 || upd_valid !== 1'b0) begin
            failures++; $display("FAIL paused got=%b/%b exp=0/0", icache_req, upd_valid); end
        rdy_in = 1'b1;
        step();
        jalr_finish = 1'b0;
        checks++; if (icache_req !== 1'b1 || icache_pc !== 32'h100) begin
            failures++; $display("FAIL jalr_target got=%b/%h exp=1/00000100", icache_req, icache_pc); end
        respond(NOP);
        checks++; if (dec_pc !== 32'h100 || icache_pc !== 32'h104) begin
            failures++; $display("FAIL jalr_resume got=%h/%h exp=00000100/00000104", dec_pc, icache_pc); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_jal();
        test_branch();
        test_full();
        test_back_to_back();
        test_flush();
        test_jalr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch_q.md
# ifetch_q

Parametrised successor to the instruction-fetch stage, sitting between the icache and the decoder/ROB. It fetches one instruction per icache transaction and predecodes JAL, branch and JALR, computing next-PC locally. Fetched instructions are buffered in a depth-configurable instruction queue, so fetch runs ahead of a stalled decoder. Mispredict flushes discard both queued instructions and any in-flight icache response.

## Interface
- IQ_DEPTH, 4, instruction-queue entries; power of two, ≥2
- RESET_PC, 32'h0, PC fetched first after reset
- BP_MODE, 1, 0 = static not-taken; 1 = dynamic predictor (pred_taken); 2 = static backward-taken/forward-not-taken
- clk_in  in  1  clock, all state on posedge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global pause when low: all state frozen, all inputs ignored
- icache_req  out  1  one-cycle request pulse
- icache_pc  out  32  fetch address, valid with icache_req
- icache_valid  in  1  one-cycle response pulse, ≥1 cycle after icache_req
- icache_inst  in  32  instruction, valid with icache_valid
- pred_pc  out  32  combinational: PC of the instruction on icache_inst
- pred_taken  in  1  combinational predictor answer for pred_pc
- upd_valid  out  1  one-cycle predictor update pulse
- upd_pc  out  32  resolved branch PC
- upd_taken  out  1  resolved direction
- dec_valid  out  1  queue head valid (count≠0)
- dec_inst  out  32  head instruction
- dec_pc  out  32  head PC
- dec_pred_taken  out  1  head prediction bit (0 for non-branches)
- dec_ready  in  1  decoder accepts head this cycle
- jalr_finish  in  1  ROB: JALR target resolved
- jalr_target  in  32  JALR target
- br_finish  in  1  ROB: branch resolved
- br_pc  in  32  resolved branch PC
- br_pred  in  1  prediction carried with the branch
- br_taken  in  1  actual direction
- br_redirect_pc  in  32  correct next PC on mispredict
- iq_count  out  clog2(IQ_DEPTH)+1  current queue occupancy

## Operation
- Reset (rst_in low, async): pc=RESET_PC; state IDLE; queue empty; drop flag 0; icache_req=0, icache_pc=0, upd_valid=0, upd_pc=0, upd_taken=0, iq_count=0, dec_valid=0.
- FSM IDLE: if iq_count<IQ_DEPTH, pulse icache_req with icache_pc=pc and go to WAIT_IC. Otherwise hold.
- FSM WAIT_IC: on icache_valid, predecode opcode [6:0], enqueue {inst, pc, pred}, then go to IDLE, except JALR:
  - JAL 1101111: pc ← pc + sext(J-imm).
  - Branch 1100011: taken = (BP_MODE==1 ? pred_taken : BP_MODE==2 ? B-imm[12] : 0). pc ← taken ? pc + sext(B-imm) : pc+4. Enqueued pred = taken.
  - JALR 1100111: enqueue, then go to STALL_JALR; pc unchanged.
  - Any other opcode: pc ← pc+4.
- FSM STALL_JALR: no requests; on jalr_finish, pc ← jalr_target and go to IDLE.
- Dequeue: pop the head when dec_valid && dec_ready. Push and pop in the same cycle leave the count unchanged. At most one request is in flight and issue requires a free slot, so overflow is impossible.
- Flush, when br_finish && br_pred≠br_taken:
  - queue cleared, pc ← br_redirect_pc, state ← IDLE;
  - if in WAIT_IC and no icache_valid this cycle, set the drop flag;
  - any icache_valid in the flush cycle is discarded.
- Drop flag: the next icache_valid is discarded and clears the flag. No new request is issued while the flag is set.
- Every br_finish (mispredicted or not) drives upd_valid=1 next cycle with upd_pc=br_pc, upd_taken=br_taken.
- Priority: flush > jalr_finish > normal fetch. A flush during STALL_JALR exits to IDLE at br_redirect_pc.
- Arithmetic is 32-bit modulo 2^32; immediates are sign-extended before the add.

## Timing
- icache_valid at cycle t → entry visible on dec_valid at t+1. icache_req can re-issue at t+1.
- Peak throughput is one instruction per (icache latency+1) cycles.
- Flush at t: dec_valid=0 at t+1; first redirected icache_req at t+1 if no response is outstanding, else 1 cycle after the dropped response.
- jalr_finish at t: icache_req with jalr_target at t+1.
- upd_valid is registered, one cycle after br_finish.
- rdy_in low: no request, no push, no pop, no update pulse; outputs hold.

## Test plan
- Straight-line ADDI stream from RESET_PC=0, decoder always ready, icache latency 1 → dec_pc sequence 0,4,8,… with dec_pred_taken=0.
- JAL at 0x10 with imm +0x20 → next icache_pc=0x30; no fetch of 0x14.
- BP_MODE=2, branch at 0x40 with imm −8 → pred bit 1, next icache_pc=0x38. BP_MODE=0, same branch → next icache_pc=0x44.
- dec_ready=0 with IQ_DEPTH=4 → exactly 4 entries, iq_count=4, no icache_req until one pop.
- JALR at 0x20 → no requests; jalr_finish with target 0x100 → icache_req pc=0x100 next cycle.
- Flush (br_pred=1, br_taken=0, br_redirect_pc=0x80) while a request is outstanding → queue empty, stale response discarded, next fetch 0x80, upd_valid pulse with upd_taken=0.
